pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Sequences control-flow redirection for the in-order core. It consumes the execute-stage result (valid, pc, branch, trap, trap-return) and produces front-end flush/stall, the fetch redirect, and the CSR trap-entry and trap-return commit pulses. Branches redirect in one cycle. Traps and trap-returns run a multi-cycle drain → commit → redirect sequence, so CSR state changes only after older memory operations complete.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of pc/target/trap value
- CAUSE_WIDTH, 4, trap cause width
- MIN_DRAIN, 2, minimum cycles spent in DRAIN (1..15)

Ports (clock and reset first; one clock `clk`, reset `rst` is synchronous and active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- exValid  in  1  execute stage holds a valid insn
- exPc  in  ADDR_WIDTH  pc of that insn
- exBranchTaken  in  1  branch/jump taken
- exBranchTarget  in  ADDR_WIDTH  branch target
- exTrapValid  in  1  insn raised a trap
- exTrapCause  in  CAUSE_WIDTH  trap cause
- exTrapValue  in  ADDR_WIDTH  trap value (tval)
- exTrapReturn  in  1  insn is xRET
- memBusy  in  1  memory stage / store buffer has outstanding ops
- trapVector  in  ADDR_WIDTH  current tvec from CSR file
- trapEpc  in  ADDR_WIDTH  current epc from CSR file
- flush  out  1  kill all stages younger than memory, including the execute output this cycle
- stall  out  1  hold fetch/decode
- redirectValid  out  1  fetch must load redirectPc
- redirectPc  out  ADDR_WIDTH  new fetch pc
- csrTrapEnter  out  1  one-cycle pulse: CSR file records trap
- csrTrapReturn  out  1  one-cycle pulse: CSR file performs xRET
- csrEpc, csrCause, csrTval  out  ADDR_WIDTH/CAUSE_WIDTH/ADDR_WIDTH  values qualified by csrTrapEnter

## Operation
- Accepted event: exValid=1 and flush=0, in state RUN only. Priority: trap > trapReturn > branch.
- States: RUN, DRAIN, COMMIT, REDIRECT.
- RUN, branch accepted: next cycle redirectValid=1, redirectPc=exBranchTarget, flush=1. State stays RUN.
- RUN, trap or trapReturn accepted:
  - Latch pc, cause, tval and kind (trap/return).
  - Next state DRAIN. Load drain counter with MIN_DRAIN.
- DRAIN: flush=1, stall=1. Counter decrements to 0. Exit to COMMIT when counter==0 and memBusy==0. memBusy stuck high holds DRAIN indefinitely; there is no timeout.
- COMMIT: stall=1, flush=1. Exactly one of csrTrapEnter/csrTrapReturn pulses. csrEpc=latched pc. Next state REDIRECT.
- REDIRECT: redirectValid=1, flush=1, stall=0. redirectPc is sampled combinationally this cycle, one cycle after the CSR write:
  - trap: {trapVector[ADDR_WIDTH-1:2],2'b00}; tvec mode bits are ignored.
  - return: trapEpc.
  - Next state RUN.
- Inputs are ignored in DRAIN/COMMIT/REDIRECT and in any cycle with flush=1. This is the branch shadow: the younger insn in execute is squashed.
- A trap and a branch taken on the same insn: the trap wins and the branch target is discarded.

## Timing
- Reset: state RUN, counter 0, latches 0. All outputs 0 in the cycle after rst is sampled high.
- rst high in any state returns to RUN next cycle. No pending CSR pulse or redirect is emitted.
- Branch latency: detect cycle N → redirect/flush in cycle N+1.
- Trap latency with memBusy=0: detect N → DRAIN N+1..N+MIN_DRAIN → COMMIT N+MIN_DRAIN+1 → REDIRECT N+MIN_DRAIN+2.
- Outputs are registered, except redirectPc in REDIRECT, which is a mux of trapVector/trapEpc.
- Back-to-back accepted events are impossible: minimum spacing is 2 cycles, because of the shadow.

## Structure
- Shared package `RafiTypes`:
  - enum PipelineCtrlState {RUN, DRAIN, COMMIT, REDIRECT}
  - typedef for the latched trap record (pc, cause, tval, isReturn), shared with the CSR file
- Drain counter inline; no sub-module. The next-pc select is a small inline mux.

## Test plan
- Branch: exValid=1, exBranchTaken=1, exBranchTarget=0x100 at cycle 5. Required at cycle 6: redirectValid=1, redirectPc=0x100, flush=1. Required at cycle 7: all low. An exValid branch at cycle 6 to 0x200 is ignored.
- Trap, idle memory: exTrapValid=1, exPc=0x40, exTrapCause=2, exTrapValue=0xDEAD, trapVector=0x8001, MIN_DRAIN=2, memBusy=0. Required:
  - csrTrapEnter pulses exactly once, 3 cycles after detect, with csrEpc=0x40, csrCause=2, csrTval=0xDEAD.
  - Next cycle: redirectPc=0x8000.
- Drain wait: same trap with memBusy=1 for 10 cycles. COMMIT is delayed until the cycle after memBusy falls. stall stays high throughout.
- Trap-return: exTrapReturn=1, trapEpc=0x1234. Required: csrTrapReturn pulse, then redirectPc=0x1234. csrTrapEnter is never asserted.
- Priority: exTrapValid=1 and exBranchTaken=1 together, target 0x300. Required: trap sequence only; no redirect to 0x300.
- Reset mid-sequence: rst=1 during DRAIN. Required next cycle: all outputs 0 and state RUN. No CSR pulse occurs afterwards.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: control-flow sequencer state and trap record shared with the CSR file
package pipeline_controller_pkg;
  localparam int REC_ADDR_W = 32;
  localparam int REC_CAUSE_W = 4;
  typedef enum logic [1:0] {RUN, DRAIN, COMMIT, REDIRECT} pipeline_ctrl_state_e;
  typedef struct packed {
    logic [REC_ADDR_W-1:0] pc;
    logic [REC_CAUSE_W-1:0] cause;
    logic [REC_ADDR_W-1:0] tval;
    logic is_return;
  } trap_rec_t;
endpackage

// File: rtl/pipeline_controller.sv
// pipeline_controller: branch redirect plus drain/commit/redirect sequencing for traps and xRET
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CAUSE_WIDTH = 4,
  parameter int MIN_DRAIN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exValid,
  input  logic [ADDR_WIDTH-1:0]  exPc,
  input  logic                   exBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  exBranchTarget,
  input  logic                   exTrapValid,
  input  logic [CAUSE_WIDTH-1:0] exTrapCause,
  input  logic [ADDR_WIDTH-1:0]  exTrapValue,
  input  logic                   exTrapReturn,
  input  logic                   memBusy,
  input  logic [ADDR_WIDTH-1:0]  trapVector,
  input  logic [ADDR_WIDTH-1:0]  trapEpc,
  output logic                   flush,
  output logic                   stall,
  output logic                   redirectValid,
  output logic [ADDR_WIDTH-1:0]  redirectPc,
  output logic                   csrTrapEnter,
  output logic                   csrTrapReturn,
  output logic [ADDR_WIDTH-1:0]  csrEpc,
  output logic [CAUSE_WIDTH-1:0] csrCause,
  output logic [ADDR_WIDTH-1:0]  csrTval
);
  pipeline_ctrl_state_e state;
  logic [3:0] cnt;
  trap_rec_t rec;
  logic [ADDR_WIDTH-1:0] redir_q;
  logic accept;
  logic [3:0] cnt_next;
  assign accept = state == RUN && exValid && !flush;
  assign cnt_next = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
  assign redirectPc = state == REDIRECT ? (rec.is_return ? trapEpc : trapVector & ~ADDR_WIDTH'(3)) : redir_q;
  assign csrEpc = ADDR_WIDTH'(rec.pc);
  assign csrCause = CAUSE_WIDTH'(rec.cause);
  assign csrTval = ADDR_WIDTH'(rec.tval);
  always_ff @(posedge clk) begin
    flush <= 1'b0;
    stall <= 1'b0;
    redirectValid <= 1'b0;
    redir_q <= '0;
    csrTrapEnter <= 1'b0;
    csrTrapReturn <= 1'b0;
    if (rst) begin
      state <= RUN;
      cnt <= 4'd0;
      rec <= '0;
    end else begin
      case (state)
        RUN:
          if (accept && (exTrapValid || exTrapReturn)) begin
            state <= DRAIN;
            cnt <= 4'(MIN_DRAIN);
            rec <= '{pc: REC_ADDR_W'(exPc), cause: REC_CAUSE_W'(exTrapCause),
                     tval: REC_ADDR_W'(exTrapValue), is_return: !exTrapValid};
            flush <= 1'b1;
            stall <= 1'b1;
          end else if (accept && exBranchTaken) begin
            flush <= 1'b1;
            redirectValid <= 1'b1;
            redir_q <= exBranchTarget;
          end
        DRAIN: begin
          flush <= 1'b1;
          stall <= 1'b1;
          cnt <= cnt_next;
          if (cnt_next == 4'd0 && !memBusy) begin
            state <= COMMIT;
            csrTrapEnter <= !rec.is_return;
            csrTrapReturn <= rec.is_return;
          end
        end
        COMMIT: begin
          state <= REDIRECT;
          flush <= 1'b1;
          redirectValid <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed vectors for branch, trap, drain wait, xRET, priority and reset
module tb_pipeline_controller;
  logic clk = 1'b0;
  logic rst;
  logic exValid, exBranchTaken, exTrapValid, exTrapReturn, memBusy;
  logic [31:0] exPc, exBranchTarget, exTrapValue, trapVector, trapEpc;
  logic [3:0] exTrapCause;
  logic flush, stall, redirectValid, csrTrapEnter, csrTrapReturn;
  logic [31:0] redirectPc, csrEpc, csrTval;
  logic [3:0] csrCause;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  pipeline_controller #(.ADDR_WIDTH(32), .CAUSE_WIDTH(4), .MIN_DRAIN(2)) dut (
    .clk(clk), .rst(rst), .exValid(exValid), .exPc(exPc), .exBranchTaken(exBranchTaken),
    .exBranchTarget(exBranchTarget), .exTrapValid(exTrapValid), .exTrapCause(exTrapCause),
    .exTrapValue(exTrapValue), .exTrapReturn(exTrapReturn), .memBusy(memBusy),
    .trapVector(trapVector), .trapEpc(trapEpc), .flush(flush), .stall(stall),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .csrTrapEnter(csrTrapEnter),
    .csrTrapReturn(csrTrapReturn), .csrEpc(csrEpc), .csrCause(csrCause), .csrTval(csrTval)
  );
  wire [4:0] outs = {flush, stall, redirectValid, csrTrapEnter, csrTrapReturn};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    exValid = 0; exBranchTaken = 0; exTrapValid = 0; exTrapReturn = 0;
    exPc = 0; exBranchTarget = 0; exTrapCause = 0; exTrapValue = 0;
  endtask
  task automatic trap(input logic [31:0] pc, input logic ret);
    exValid = 1; exPc = pc; exTrapValid = !ret; exTrapReturn = ret;
    exTrapCause = 4'd2; exTrapValue = 32'hDEAD;
  endtask
  initial begin
    idle();
    memBusy = 0; trapVector = 32'h8001; trapEpc = 32'h1234; rst = 1;
    step();
    chk("reset_outs", outs, 5'b00000);
    chk("reset_pc", redirectPc, 0);
    chk("reset_state", dut.state, 0);
    rst = 0;
    step();
    exValid = 1; exBranchTaken = 1; exBranchTarget = 32'h100;
    step();
    chk("br_outs", outs, 5'b10100);
    chk("br_pc", redirectPc, 32'h100);
    exBranchTarget = 32'h200;
    step();
    idle();
    chk("br_shadow_outs", outs, 5'b00000);
    chk("br_shadow_pc", redirectPc, 0);
    trap(32'h40, 0);
    step();
    idle();
    chk("trap_drain1", outs, 5'b11000);
    step();
    chk("trap_drain2", outs, 5'b11000);
    step();
    chk("trap_commit", outs, 5'b11010);
    chk("trap_epc", csrEpc, 32'h40);
    chk("trap_cause", csrCause, 2);
    chk("trap_tval", csrTval, 32'hDEAD);
    step();
    chk("trap_redir", outs, 5'b10100);
    chk("trap_redir_pc", redirectPc, 32'h8000);
    step();
    chk("trap_done", outs, 5'b00000);
    trap(32'h44, 0);
    memBusy = 1;
    step();
    idle();
    for (int i = 1; i < 10; i++) begin
      chk("busy_drain", outs, 5'b11000);
      step();
    end
    memBusy = 0;
    chk("busy_last_drain", outs, 5'b11000);
    step();
    chk("busy_commit", outs, 5'b11010);
    chk("busy_epc", csrEpc, 32'h44);
    step();
    chk("busy_redir_pc", redirectPc, 32'h8000);
    step();
    trap(32'h50, 1);
    step();
    idle();
    chk("ret_drain", outs, 5'b11000);
    step();
    step();
    chk("ret_commit", outs, 5'b11001);
    step();
    chk("ret_redir", outs, 5'b10100);
    chk("ret_redir_pc", redirectPc, 32'h1234);
    step();
    chk("ret_done", outs, 5'b00000);
    trap(32'h60, 0);
    exBranchTaken = 1; exBranchTarget = 32'h300;
    step();
    idle();
    chk("prio_drain", outs, 5'b11000);
    chk("prio_pc", redirectPc, 0);
    step();
    step();
    chk("prio_commit", outs, 5'b11010);
    chk("prio_epc", csrEpc, 32'h60);
    step();
    chk("prio_redir_pc", redirectPc, 32'h8000);
    step();
    trap(32'h70, 0);
    step();
    idle();
    chk("rst_mid_drain", outs, 5'b11000);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mid_outs", outs, 5'b00000);
    chk("rst_mid_state", dut.state, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_after_outs", outs, 5'b00000);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
